// File: rtl/effect_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : effect_sequencer_if
// Description : Effect-stage handshake bundle between the sequencer and the
//               chain of effect stages (tremolo and peers).
//               fx_cs       - per-stage chip select (enable snapshot)
//               fx_my_turn  - one-hot grant, stage i is active
//               fx_data_in  - shared sample bus to all stages
//               fx_done     - stage i finished (1-cycle pulse)
//               fx_data_out - stage i result in bits [i*DATA_WIDTH +: DATA_WIDTH]
//               master: sequencer side, slave: effect-stage side.
// Revision    : 1.0 - initial release
// ============================================================================
interface effect_sequencer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_EFFECTS = 4
);
    logic [NUM_EFFECTS-1:0]            fx_cs;
    logic [NUM_EFFECTS-1:0]            fx_my_turn;
    logic [DATA_WIDTH-1:0]             fx_data_in;
    logic [NUM_EFFECTS-1:0]            fx_done;
    logic [NUM_EFFECTS*DATA_WIDTH-1:0] fx_data_out;

    modport master (
        output fx_cs,
        output fx_my_turn,
        output fx_data_in,
        input  fx_done,
        input  fx_data_out
    );

    modport slave (
        input  fx_cs,
        input  fx_my_turn,
        input  fx_data_in,
        output fx_done,
        output fx_data_out
    );
endinterface
`default_nettype wire

// File: rtl/effect_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : effect_sequencer
// Description : Upstream scheduler for the effects chain. Accepts one codec
//               sample, hands it to each enabled effect stage in turn via the
//               cs/my_turn/done handshake, chains each result into the next
//               stage and returns the final sample. Disabled stages bypass.
// Ports       : clk, rst (async, active-high)
//               sample_valid/sample_in/effect_en - codec sample input
//               fx (effect_sequencer_if.master)  - effect-stage bus
//               out_valid/sample_out             - processed sample
//               busy, overrun (pulse), timeout_err (sticky)
// Macro       : FX_TIMEOUT_EN - builds the per-stage watchdog; otherwise a
//               stage may take indefinitely and timeout_err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module effect_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_EFFECTS    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   sample_valid,
    input  wire logic [DATA_WIDTH-1:0]  sample_in,
    input  wire logic [NUM_EFFECTS-1:0] effect_en,
    effect_sequencer_if.master          fx,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       sample_out,
    output logic                        busy,
    output logic                        overrun,
    output logic                        timeout_err
);

    localparam int IDX_W = $clog2(NUM_EFFECTS + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SELECT = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_OUTPUT = 2'd3;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]             r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_WIDTH-1:0]  r_cur;
    logic [NUM_EFFECTS-1:0] r_en_snap;
    logic [NUM_EFFECTS-1:0] r_my_turn;
    logic [DATA_WIDTH-1:0]  r_sample_out;
    logic                   r_out_valid;
    logic                   r_overrun;

    logic                   w_last;
    logic                   w_sel_en;
    logic                   w_sel_done;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic [NUM_EFFECTS-1:0] w_grant;
    logic                   w_tmo_hit;

    // Per-index selection done by comparison rather than direct indexing so
    // idx == NUM_EFFECTS (the "all stages visited" value) never reads past
    // the end of any vector.
    always_comb begin
        w_sel_en   = 1'b0;
        w_sel_done = 1'b0;
        w_sel_data = '0;
        w_grant    = '0;
        for (int i = 0; i < NUM_EFFECTS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_en   = r_en_snap[i];
                w_sel_done = fx.fx_done[i];
                w_sel_data = fx.fx_data_out[i*DATA_WIDTH +: DATA_WIDTH];
                w_grant[i] = 1'b1;
            end
        end
    end

    assign w_last = (r_idx == IDX_W'(NUM_EFFECTS));

`ifdef FX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_timeout_err;

    // Hit on the TIMEOUT_CYCLES-th WAIT cycle without a matching done.
    assign w_tmo_hit = (r_state == c_WAIT) && !w_sel_done &&
                       (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // WAIT is only ever entered from SELECT, so clearing in SELECT is the
    // same as clearing on entry to WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == c_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_tmo_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_tmo_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_idx        <= '0;
            r_cur        <= '0;
            r_en_snap    <= '0;
            r_my_turn    <= '0;
            r_sample_out <= '0;
            r_out_valid  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            // A sample arriving outside IDLE is dropped; only flag it.
            r_overrun   <= sample_valid && (r_state != c_IDLE);
            case (r_state)
                c_IDLE: begin
                    if (sample_valid) begin
                        r_cur     <= sample_in;
                        r_en_snap <= effect_en;
                        r_idx     <= '0;
                        r_state   <= c_SELECT;
                    end
                end
                c_SELECT: begin
                    if (w_last) begin
                        r_state <= c_OUTPUT;
                    end else if (w_sel_en) begin
                        r_my_turn <= w_grant;
                        r_state   <= c_WAIT;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                c_WAIT: begin
                    if (w_sel_done) begin
                        r_cur     <= w_sel_data;
                        r_my_turn <= '0;
                        r_idx     <= r_idx + IDX_W'(1);
                        r_state   <= c_SELECT;
                    end else if (w_tmo_hit) begin
                        // Stage is skipped: cur keeps the value it was given.
                        r_my_turn <= '0;
                        r_idx     <= r_idx + IDX_W'(1);
                        r_state   <= c_SELECT;
                    end
                end
                c_OUTPUT: begin
                    r_sample_out <= r_cur;
                    r_out_valid  <= 1'b1;
                    r_state      <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign fx.fx_cs      = r_en_snap;
    assign fx.fx_my_turn = r_my_turn;
    assign fx.fx_data_in = r_cur;
    assign out_valid     = r_out_valid;
    assign sample_out    = r_sample_out;
    assign busy          = (r_state != c_IDLE);
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_effect_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_effect_sequencer
// Description : Directed self-checking bench for effect_sequencer with
//               NUM_EFFECTS=4, DATA_WIDTH=16, TIMEOUT_CYCLES=16. The bench
//               plays the part of the effect stages directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_effect_sequencer;

    localparam int DW = 16;
    localparam int NE = 4;
    localparam int TO = 16;

    logic          clk          = 1'b0;
    logic          rst          = 1'b1;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_in    = '0;
    logic [NE-1:0] effect_en    = '0;
    logic          out_valid;
    logic [DW-1:0] sample_out;
    logic          busy;
    logic          overrun;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    effect_sequencer_if #(.DATA_WIDTH(DW), .NUM_EFFECTS(NE)) fx ();

    effect_sequencer #(
        .DATA_WIDTH     (DW),
        .NUM_EFFECTS    (NE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .effect_en    (effect_en),
        .fx           (fx.master),
        .out_valid    (out_valid),
        .sample_out   (sample_out),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_turn(input logic [NE-1:0] want, input string tag);
        int n = 0;
        while (fx.fx_my_turn !== want && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_turn_reached"}, 32'(fx.fx_my_turn), 32'(want));
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_out_valid_seen"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        int n;
        fx.fx_done     = '0;
        fx.fx_data_out = '0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid",  32'(out_valid),      32'd0);
        chk("rst_sample_out", 32'(sample_out),     32'd0);
        chk("rst_busy",       32'(busy),           32'd0);
        chk("rst_my_turn",    32'(fx.fx_my_turn),  32'd0);
        chk("rst_cs",         32'(fx.fx_cs),       32'd0);
        chk("rst_data_in",    32'(fx.fx_data_in),  32'd0);
        chk("rst_overrun",    32'(overrun),        32'd0);
        chk("rst_timeout",    32'(timeout_err),    32'd0);
        rst = 1'b0;
        tick();

        // 1: all stages bypassed, out_valid exactly 6 cycles after acceptance
        sample_in    = 16'h1234;
        effect_en    = 4'b0000;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("t1_my_turn", 32'(fx.fx_my_turn), 32'd0);
            if (k < 6) begin
                chk("t1_out_valid_early", 32'(out_valid), 32'd0);
            end else begin
                chk("t1_out_valid",  32'(out_valid),  32'd1);
                chk("t1_sample_out", 32'(sample_out), 32'h1234);
            end
        end
        tick();
        chk("t1_strobe_1cyc", 32'(out_valid),  32'd0);
        chk("t1_held",        32'(sample_out), 32'h1234);
        chk("t1_idle",        32'(busy),       32'd0);

        // 2: only stage 1 enabled, stage answers after 10 cycles
        sample_in    = 16'h5555;
        effect_en    = 4'b0010;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        effect_en    = 4'b1111;   // must not disturb the snapshot
        wait_turn(4'b0010, "t2");
        chk("t2_cs", 32'(fx.fx_cs), 32'h2);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t2_turn_hold", 32'(fx.fx_my_turn), 32'h2);
            chk("t2_data_in",   32'(fx.fx_data_in), 32'h5555);
        end
        fx.fx_data_out = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
        fx.fx_done     = 4'b0001;  // wrong stage: ignored
        tick();
        fx.fx_done = 4'b0000;
        chk("t2_foreign_done", 32'(fx.fx_my_turn), 32'h2);
        chk("t2_foreign_data", 32'(fx.fx_data_in), 32'h5555);
        fx.fx_data_out = {16'h0000, 16'h0000, 16'h0ABC, 16'h0000};
        fx.fx_done     = 4'b0010;
        tick();
        fx.fx_done = 4'b0000;
        chk("t2_turn_drop", 32'(fx.fx_my_turn), 32'd0);
        wait_out("t2");
        chk("t2_sample_out", 32'(sample_out), 32'h0ABC);

        // 3: stages 0 and 2; stubs produce in+1 then in*2
        tick();
        sample_in    = 16'h0003;
        effect_en    = 4'b0101;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        wait_turn(4'b0001, "t3_s0");
        chk("t3_s0_data_in", 32'(fx.fx_data_in), 32'h0003);
        fx.fx_data_out = {16'h0000, 16'h0000, 16'h0000, 16'h0004};
        fx.fx_done     = 4'b0001;
        tick();
        fx.fx_done = 4'b0000;
        wait_turn(4'b0100, "t3_s2");
        chk("t3_s2_data_in", 32'(fx.fx_data_in), 32'h0004);
        chk("t3_cs",         32'(fx.fx_cs),      32'h5);
        fx.fx_data_out = {16'h0000, 16'h0008, 16'h0000, 16'h0000};
        fx.fx_done     = 4'b0100;
        tick();
        fx.fx_done = 4'b0000;
        wait_out("t3");
        chk("t3_sample_out", 32'(sample_out), 32'h0008);

        // 4: second sample while busy -> overrun, first sample unaffected
        tick();
        sample_in    = 16'hAAAA;
        effect_en    = 4'b0000;
        sample_valid = 1'b1;
        tick();
        sample_in = 16'hBBBB;
        tick();
        sample_valid = 1'b0;
        chk("t4_overrun", 32'(overrun), 32'd1);
        tick();
        chk("t4_overrun_1cyc", 32'(overrun), 32'd0);
        wait_out("t4");
        chk("t4_sample_out", 32'(sample_out), 32'hAAAA);
        tick();
        tick();
        chk("t4_no_second", 32'(busy), 32'd0);

        // 5: reset during WAIT, then a normal sample
        sample_in    = 16'h7777;
        effect_en    = 4'b0001;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        wait_turn(4'b0001, "t5");
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_turn",   32'(fx.fx_my_turn), 32'd0);
        chk("t5_rst_busy",   32'(busy),          32'd0);
        chk("t5_rst_out",    32'(sample_out),    32'd0);
        chk("t5_rst_cs",     32'(fx.fx_cs),      32'd0);
        tick();
        rst = 1'b0;
        tick();
        sample_in    = 16'h4321;
        effect_en    = 4'b0000;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        wait_out("t5");
        chk("t5_sample_out", 32'(sample_out), 32'h4321);

`ifdef FX_TIMEOUT_EN
        // 6: stage 0 never answers -> timeout after 16 cycles, sample unchanged
        tick();
        sample_in    = 16'h1357;
        effect_en    = 4'b0001;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        wait_turn(4'b0001, "t6");
        chk("t6_no_err_yet", 32'(timeout_err), 32'd0);
        n = 0;
        while (fx.fx_my_turn !== 4'b0000 && n < 100) begin
            tick();
            n++;
        end
        chk("t6_cycles",  32'(n),           32'd16);
        chk("t6_err",     32'(timeout_err), 32'd1);
        wait_out("t6");
        chk("t6_sample_out", 32'(sample_out), 32'h1357);
        chk("t6_sticky",     32'(timeout_err), 32'd1);
`else
        n = 0;
        chk("no_timeout_err", 32'(timeout_err), 32'(n));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
